memory_stage: RTL and testbench

Memory stage of the pipelined Y86-64 processor, including the M→W pipeline register. It takes the execute-stage result (icode, cond, rA, rB, valE, valA, valP, stat) and performs the data-memory read or write for that instruction. It then registers everything the writeback stage needs: cond, icode, rA, rB, valE, valM and stat. It also drives the combinational m_valM and m_stat signals used by decode forwarding and by the hazard control.

---
 rtl/memory_stage.sv | 148 ++++++++++++++
 tb/tb_memory_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: data-memory access for the M instruction plus the M->W
// pipeline register feeding writeback.
module memory_stage #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_cond,
    input  logic [3:0]  e_rA,
    input  logic [3:0]  e_rB,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [63:0] e_valP,
    input  logic        w_stall,
    input  logic        w_bubble,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic        W_cond,
    output logic [3:0]  W_rA,
    output logic [3:0]  W_rB,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    logic [63:0]       mem_q [DEPTH];
    logic [63:0]       addr;
    logic [63:0]       wrData;
    logic              isRead;
    logic              isWrite;
    logic              adrErr;
    logic              memWe;
    logic [ADDR_W-1:0] memIdx;

    logic [2:0]  stat_q,  stat_d;
    logic [3:0]  icode_q, icode_d;
    logic        cond_q,  cond_d;
    logic [3:0]  rA_q,    rA_d;
    logic [3:0]  rB_q,    rB_d;
    logic [63:0] valE_q,  valE_d;
    logic [63:0] valM_q,  valM_d;

    // Stack pops read through valA (old %rsp); everything else addresses via valE.
    always_comb begin
        addr    = '0;
        wrData  = '0;
        isRead  = 1'b0;
        isWrite = 1'b0;
        case (e_icode)
            I_MRMOVQ: begin addr = e_valE; isRead = 1'b1; end
            I_POPQ,
            I_RET:    begin addr = e_valA; isRead = 1'b1; end
            I_RMMOVQ,
            I_PUSHQ:  begin addr = e_valE; isWrite = 1'b1; wrData = e_valA; end
            I_CALL:   begin addr = e_valE; isWrite = 1'b1; wrData = e_valP; end
            default:  ;
        endcase
    end

    assign adrErr = (addr[2:0] != 3'b000) || (addr[63:ADDR_W+3] != '0);
    assign memIdx = addr[ADDR_W+2:3];
    assign m_stat = ((isRead || isWrite) && adrErr) ? STAT_ADR : e_stat;
    assign m_valM = (isRead && !adrErr) ? mem_q[memIdx] : 64'd0;

    // A store commits only when nothing ahead of it has faulted or halted.
    assign memWe = isWrite && (m_stat == STAT_AOK) && (stat_q == STAT_AOK)
                   && !w_stall && !rst;

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[memIdx] <= wrData;
        end
    end

    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        cond_d  = cond_q;
        rA_d    = rA_q;
        rB_d    = rB_q;
        valE_d  = valE_q;
        valM_d  = valM_q;
        if (w_stall) begin
            // hold everything
        end else if (w_bubble) begin
            stat_d  = STAT_AOK;
            icode_d = I_NOP;
            cond_d  = 1'b0;
            rA_d    = REG_NONE;
            rB_d    = REG_NONE;
            valE_d  = '0;
            valM_d  = '0;
        end else begin
            stat_d  = m_stat;
            icode_d = e_icode;
            cond_d  = e_cond;
            rA_d    = e_rA;
            rB_d    = e_rB;
            valE_d  = e_valE;
            valM_d  = m_valM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q  <= STAT_AOK;
            icode_q <= I_NOP;
            cond_q  <= 1'b0;
            rA_q    <= REG_NONE;
            rB_q    <= REG_NONE;
            valE_q  <= '0;
            valM_q  <= '0;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cond_q  <= cond_d;
            rA_q    <= rA_d;
            rB_q    <= rB_d;
            valE_q  <= valE_d;
            valM_q  <= valM_d;
        end
    end

    assign W_stat  = stat_q;
    assign W_icode = icode_q;
    assign W_cond  = cond_q;
    assign W_rA    = rA_q;
    assign W_rB    = rB_q;
    assign W_valE  = valE_q;
    assign W_valM  = valM_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed Y86 scenarios followed by random
// traffic, checked against a word-addressed reference memory.
module tb_memory_stage;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_cond;
    logic [3:0]  e_rA, e_rB;
    logic [63:0] e_valE, e_valA, e_valP;
    logic        w_stall, w_bubble;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic        W_cond;
    logic [3:0]  W_rA, W_rB;
    logic [63:0] W_valE, W_valM;

    memory_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .e_stat(e_stat), .e_icode(e_icode), .e_cond(e_cond),
        .e_rA(e_rA), .e_rB(e_rB),
        .e_valE(e_valE), .e_valA(e_valA), .e_valP(e_valP),
        .w_stall(w_stall), .w_bubble(w_bubble),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_cond(W_cond),
        .W_rA(W_rA), .W_rB(W_rB), .W_valE(W_valE), .W_valM(W_valM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cond;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valE;
        logic [63:0] valM;
    } wExp_t;

    typedef struct {
        logic [63:0] valM;
        logic [2:0]  stat;
    } combExp_t;

    wExp_t    expW[$];
    combExp_t expC[$];
    int       checks = 0;
    int       errors = 0;

    longint unsigned refMem [longint unsigned];
    wExp_t           refW;
    wExp_t           resetW = '{3'd1, 4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0};

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic checkW(input string tag, input wExp_t e);
        checkOutput({tag, " W_stat"},  64'(W_stat),  64'(e.stat));
        checkOutput({tag, " W_icode"}, 64'(W_icode), 64'(e.icode));
        checkOutput({tag, " W_cond"},  64'(W_cond),  64'(e.cond));
        checkOutput({tag, " W_rA"},    64'(W_rA),    64'(e.rA));
        checkOutput({tag, " W_rB"},    64'(W_rB),    64'(e.rB));
        checkOutput({tag, " W_valE"},  W_valE,       e.valE);
        checkOutput({tag, " W_valM"},  W_valM,       e.valM);
    endtask

    // Drives one instruction and predicts its combinational and registered results.
    task automatic driveCycle(input logic [3:0] icode, input logic [2:0] stat,
                              input logic cond, input logic [3:0] rA, input logic [3:0] rB,
                              input logic [63:0] valE, input logic [63:0] valA,
                              input logic [63:0] valP, input logic stall, input logic bubble);
        longint unsigned addr;
        bit              rd, wr, bad;
        logic [2:0]      mStat;
        logic [63:0]     mValM;
        e_icode = icode; e_stat = stat; e_cond = cond; e_rA = rA; e_rB = rB;
        e_valE = valE; e_valA = valA; e_valP = valP; w_stall = stall; w_bubble = bubble;
        rd    = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
        wr    = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
        addr  = (icode == 4'h9 || icode == 4'hB) ? valA : valE;
        bad   = (addr % 8 != 0) || (addr >= 64'(DEPTH) * 8);
        mStat = ((rd || wr) && bad) ? 3'd3 : stat;
        mValM = 64'd0;
        if (rd && !bad && refMem.exists(addr / 8)) mValM = refMem[addr / 8];
        expC.push_back('{mValM, mStat});
        if (wr && mStat == 3'd1 && refW.stat == 3'd1 && !stall)
            refMem[addr / 8] = (icode == 4'h8) ? valP : valA;
        if (!stall) begin
            if (bubble) refW = '{3'd1, 4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0};
            else        refW = '{mStat, icode, cond, rA, rB, valE, mValM};
        end
        expW.push_back(refW);
    endtask

    task automatic applyStimulus(input logic [3:0] icode, input logic [2:0] stat,
                                 input logic cond, input logic [3:0] rA, input logic [3:0] rB,
                                 input logic [63:0] valE, input logic [63:0] valA,
                                 input logic [63:0] valP, input logic stall, input logic bubble);
        @(posedge clk);
        #2;
        driveCycle(icode, stat, cond, rA, rB, valE, valA, valP, stall, bubble);
    endtask

    function automatic logic [63:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 64'($urandom_range(0, 15)) * 8;
        if (r < 8) return 64'($urandom_range(0, DEPTH - 1)) * 8;
        if (r == 8) return 64'($urandom_range(0, DEPTH * 8 - 1)) | 64'h1;
        return {$urandom(), $urandom()} | 64'(DEPTH * 8);
    endfunction

    // Combinational monitor: mid-cycle, inputs are stable.
    initial begin
        combExp_t c;
        forever begin
            @(negedge clk);
            if (expC.size() > 0) begin
                c = expC.pop_front();
                checkOutput("m_valM", m_valM, c.valM);
                checkOutput("m_stat", 64'(m_stat), 64'(c.stat));
            end
        end
    end

    // Registered monitor: just after the edge that loaded W.
    initial begin
        wExp_t w;
        forever begin
            @(posedge clk);
            #1;
            if (expW.size() > 0) begin
                w = expW.pop_front();
                checkW("pipe", w);
            end
        end
    end

    initial begin
        refW = resetW;
        rst = 1'b1;
        e_icode = 4'h1; e_stat = 3'd1; e_cond = 1'b0; e_rA = 4'hF; e_rB = 4'hF;
        e_valE = '0; e_valA = '0; e_valP = '0; w_stall = 1'b0; w_bubble = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkW("reset", resetW);

        // store then load
        applyStimulus(4'h4, 3'd1, 1'b0, 4'h1, 4'h2, 64'h40, 64'hDEADBEEF, 64'h0, 1'b0, 1'b0);
        applyStimulus(4'h5, 3'd1, 1'b0, 4'h3, 4'hF, 64'h40, 64'h0, 64'h0, 1'b0, 1'b0);
        // call / ret
        applyStimulus(4'h8, 3'd1, 1'b0, 4'hF, 4'h4, 64'h1F8, 64'h200, 64'h123, 1'b0, 1'b0);
        applyStimulus(4'h9, 3'd1, 1'b0, 4'hF, 4'h4, 64'h200, 64'h1F8, 64'h0, 1'b0, 1'b0);
        // address error, suppressed store behind it, then read back
        applyStimulus(4'h5, 3'd1, 1'b0, 4'h3, 4'hF, 64'h43, 64'h0, 64'h0, 1'b0, 1'b0);
        applyStimulus(4'h4, 3'd1, 1'b0, 4'h1, 4'h2, 64'h48, 64'h5, 64'h0, 1'b0, 1'b0);
        applyStimulus(4'h5, 3'd1, 1'b0, 4'h6, 4'hF, 64'h48, 64'h0, 64'h0, 1'b0, 1'b0);
        // stall and bubble
        applyStimulus(4'h3, 3'd1, 1'b0, 4'hF, 4'h2, 64'h7, 64'h0, 64'h0, 1'b0, 1'b0);
        applyStimulus(4'h4, 3'd1, 1'b1, 4'h5, 4'h6, 64'h80, 64'h99, 64'h0, 1'b1, 1'b0);
        applyStimulus(4'h6, 3'd2, 1'b1, 4'h7, 4'h8, 64'h55, 64'h11, 64'h0, 1'b1, 1'b0);
        applyStimulus(4'hA, 3'd1, 1'b0, 4'h4, 4'h4, 64'h88, 64'h77, 64'h0, 1'b1, 1'b1);
        applyStimulus(4'h6, 3'd1, 1'b1, 4'h1, 4'h2, 64'h33, 64'h0, 64'h0, 1'b0, 1'b1);
        applyStimulus(4'h5, 3'd1, 1'b0, 4'h1, 4'hF, 64'h80, 64'h0, 64'h0, 1'b0, 1'b0);

        // reset arriving mid-cycle with a pushq pending
        @(posedge clk);
        #2;
        e_icode = 4'hA; e_stat = 3'd1; e_cond = 1'b0; e_rA = 4'h3; e_rB = 4'h4;
        e_valE = 64'h100; e_valA = 64'hCAFE; e_valP = '0; w_stall = 1'b0; w_bubble = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkW("midreset", resetW);
        refW = resetW;
        @(posedge clk);
        #2;
        rst = 1'b0;
        driveCycle(4'h5, 3'd1, 1'b0, 4'h2, 4'hF, 64'h100, 64'h0, 64'h0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] st;
            st = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            applyStimulus(4'($urandom_range(0, 11)), st, 1'($urandom()),
                          4'($urandom()), 4'($urandom()),
                          randAddr(), randAddr(), {$urandom(), $urandom()},
                          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 10 && (expW.size() > 0 || expC.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        if (expW.size() > 0 || expC.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", expW.size() + expC.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
